timer_count_controller: RTL and testbench

- Sequencing and control unit for the 8-bit timer counter.
- Selects the count source: internal prescaler taps or the synchronised external clock pin.
- Issues single-cycle count-enable and clear pulses to the counter. Evaluates compare-match A (CTC or normal mode) and overflow.
- Holds the sticky TOV/OCFA status flags and drives the combined timer interrupt line.

---
 rtl/timer_pkg.sv | 33 +++
 rtl/timer_prescaler.sv | 65 ++++++
 rtl/timer_count_controller.sv | 129 ++++++++++++
 tb/tb_timer_count_controller.sv | 398 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared encodings for the 8-bit timer counter controller.
// Flag count depends on TIMER_COMPARE_B_EN (adds the OCFB flag when defined).
package timer_pkg;

    localparam logic [2:0] CS_STOP      = 3'b000;
    localparam logic [2:0] CS_DIV1      = 3'b001;
    localparam logic [2:0] CS_DIV8      = 3'b010;
    localparam logic [2:0] CS_DIV64     = 3'b011;
    localparam logic [2:0] CS_DIV256    = 3'b100;
    localparam logic [2:0] CS_DIV1024   = 3'b101;
    localparam logic [2:0] CS_EXT_FALL  = 3'b110;
    localparam logic [2:0] CS_EXT_RISE  = 3'b111;

    localparam logic MODE_NORMAL = 1'b0;
    localparam logic MODE_CTC    = 1'b1;

    localparam int FLAG_TOV  = 0;
    localparam int FLAG_OCFA = 1;
    localparam int FLAG_OCFB = 2;

`ifdef TIMER_COMPARE_B_EN
    localparam int NUM_FLAGS = 3;
`else
    localparam int NUM_FLAGS = 2;
`endif

    typedef enum logic [1:0] {
        STOPPED = 2'd0,
        SYNC    = 2'd1,
        RUNNING = 2'd2
    } timer_state_t;

endpackage

// File: rtl/timer_prescaler.sv
// Count-source generation: free-running prescaler, external pin synchroniser
// with edge detection, and the tick mux selected by ClockSelect.
module timer_prescaler
    import timer_pkg::*;
#(
    parameter int PRESCALE_WIDTH = 10
) (
    input  logic       SysClock,
    input  logic       SysResetN,
    input  logic       Advance,
    input  logic       Restart,
    input  logic [2:0] ClockSelect,
    input  logic       ExtClockPin,
    output logic       Tick
);

    logic [PRESCALE_WIDTH-1:0] prescale_q;
    logic [1:0]                sync_q;
    logic                      edge_q;
    logic                      rise_q;
    logic                      fall_q;
    logic                      source_hit;

    always_ff @(posedge SysClock) begin
        if (!SysResetN) begin
            prescale_q <= '0;
        end else if (Restart) begin
            prescale_q <= '0;
        end else if (Advance) begin
            prescale_q <= prescale_q + PRESCALE_WIDTH'(1);
        end
    end

    // Edge pulses are registered so a tick lands three edges after the pin moves.
    always_ff @(posedge SysClock) begin
        if (!SysResetN) begin
            sync_q <= 2'b00;
            edge_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], ExtClockPin};
            edge_q <= sync_q[1];
            rise_q <= sync_q[1] & ~edge_q;
            fall_q <= ~sync_q[1] & edge_q;
        end
    end

    always_comb begin
        source_hit = 1'b0;
        case (ClockSelect)
            CS_DIV1:     source_hit = 1'b1;
            CS_DIV8:     source_hit = &prescale_q[2:0];
            CS_DIV64:    source_hit = &prescale_q[5:0];
            CS_DIV256:   source_hit = &prescale_q[7:0];
            CS_DIV1024:  source_hit = &prescale_q[9:0];
            CS_EXT_FALL: source_hit = fall_q;
            CS_EXT_RISE: source_hit = rise_q;
            default:     source_hit = 1'b0;
        endcase
    end

    assign Tick = Advance & source_hit;

endmodule

// File: rtl/timer_count_controller.sv
// Timer counter sequencing: run-state FSM, compare/overflow evaluation, sticky
// flags and interrupt. TIMER_COMPARE_B_EN adds compare channel B (OCFB).
//
// state   | meaning
// STOPPED | ClockSelect is 000, no ticks
// SYNC    | one cycle after a source change, prescaler cleared, no tick
// RUNNING | ticks from the selected source
module timer_count_controller
    import timer_pkg::*;
#(
    parameter int BIT_WIDTH      = 8,
    parameter int PRESCALE_WIDTH = 10
) (
    input  logic                 SysClock,
    input  logic                 SysResetN,
    input  logic [2:0]           ClockSelect,
    input  logic                 TimerMode,
    input  logic [BIT_WIDTH-1:0] CompareA,
`ifdef TIMER_COMPARE_B_EN
    input  logic [BIT_WIDTH-1:0] CompareB,
`endif
    input  logic [BIT_WIDTH-1:0] CounterValue,
    input  logic                 ExtClockPin,
    input  logic                 ForceClear,
    input  logic [NUM_FLAGS-1:0] FlagClear,
    input  logic [NUM_FLAGS-1:0] IrqEnable,
    output logic                 CountEnable,
    output logic                 CounterClear,
    output logic                 OverflowFlag,
    output logic                 CompareFlagA,
`ifdef TIMER_COMPARE_B_EN
    output logic                 CompareFlagB,
`endif
    output logic                 TimerIrq
);

    localparam logic [BIT_WIDTH-1:0] COUNT_MAX = '1;

    timer_state_t          state_q;
    timer_state_t          state_d;
    logic [2:0]            cs_q;
    logic                  advance;
    logic                  restart;
    logic                  tick;
    logic                  match_a;
    logic                  at_max;
    logic                  ctc_hit;
    logic [NUM_FLAGS-1:0]  flag_set;
    logic [NUM_FLAGS-1:0]  flag_q;

    always_ff @(posedge SysClock) begin
        if (!SysResetN) begin
            state_q <= STOPPED;
            cs_q    <= CS_STOP;
        end else begin
            state_q <= state_d;
            cs_q    <= ClockSelect;
        end
    end

    // A source change while running is seen as ClockSelect != cs_q; that cycle
    // does not tick, and SYNC restarts the prescaler for the new source.
    always_comb begin
        state_d = state_q;
        advance = 1'b0;
        restart = 1'b0;
        case (state_q)
            STOPPED: begin
                if (ClockSelect != CS_STOP) state_d = SYNC;
            end
            SYNC: begin
                state_d = RUNNING;
                restart = 1'b1;
            end
            RUNNING: begin
                if (ClockSelect != cs_q) state_d = SYNC;
                else advance = ~ForceClear;
            end
            default: state_d = STOPPED;
        endcase
        if (ClockSelect == CS_STOP) state_d = STOPPED;
        if (ForceClear) restart = 1'b1;
    end

    timer_prescaler #(
        .PRESCALE_WIDTH(PRESCALE_WIDTH)
    ) u_prescaler (
        .SysClock    (SysClock),
        .SysResetN   (SysResetN),
        .Advance     (advance),
        .Restart     (restart),
        .ClockSelect (ClockSelect),
        .ExtClockPin (ExtClockPin),
        .Tick        (tick)
    );

    assign match_a = (CounterValue == CompareA);
    assign at_max  = (CounterValue == COUNT_MAX);
    assign ctc_hit = tick & (TimerMode == MODE_CTC) & match_a;

    assign CountEnable  = tick & ~ctc_hit;
    assign CounterClear = ForceClear | ctc_hit;

    always_comb begin
        flag_set            = '0;
        flag_set[FLAG_TOV]  = tick & at_max;
        flag_set[FLAG_OCFA] = tick & match_a;
`ifdef TIMER_COMPARE_B_EN
        flag_set[FLAG_OCFB] = tick & (CounterValue == CompareB);
`endif
    end

    // Set beats write-1-to-clear in the same cycle.
    always_ff @(posedge SysClock) begin
        if (!SysResetN) begin
            flag_q <= '0;
        end else begin
            flag_q <= (flag_q & ~FlagClear) | flag_set;
        end
    end

    assign OverflowFlag = flag_q[FLAG_TOV];
    assign CompareFlagA = flag_q[FLAG_OCFA];
`ifdef TIMER_COMPARE_B_EN
    assign CompareFlagB = flag_q[FLAG_OCFB];
`endif
    assign TimerIrq = |(flag_q & IrqEnable);

endmodule

// File: tb/tb_timer_count_controller.sv
// Self-checking bench for timer_count_controller: vector table, directed
// multi-cycle sequences and randomized traffic against a reference model.
`timescale 1ns/1ps
module tb_timer_count_controller;
    import timer_pkg::*;

`ifdef TIMER_COMPARE_B_EN
    localparam int NF = 3;
`else
    localparam int NF = 2;
`endif

    logic          SysClock = 1'b0;
    logic          SysResetN;
    logic [2:0]    ClockSelect;
    logic          TimerMode;
    logic [7:0]    CompareA;
    logic [7:0]    CompareB;
    logic [7:0]    CounterValue;
    logic          ExtClockPin;
    logic          ForceClear;
    logic [NF-1:0] FlagClear;
    logic [NF-1:0] IrqEnable;
    logic          CountEnable;
    logic          CounterClear;
    logic          OverflowFlag;
    logic          CompareFlagA;
    logic          CompareFlagB;
    logic          TimerIrq;

    always #5 SysClock = ~SysClock;

    timer_count_controller #(.BIT_WIDTH(8), .PRESCALE_WIDTH(10)) dut (
        .SysClock     (SysClock),
        .SysResetN    (SysResetN),
        .ClockSelect  (ClockSelect),
        .TimerMode    (TimerMode),
        .CompareA     (CompareA),
`ifdef TIMER_COMPARE_B_EN
        .CompareB     (CompareB),
`endif
        .CounterValue (CounterValue),
        .ExtClockPin  (ExtClockPin),
        .ForceClear   (ForceClear),
        .FlagClear    (FlagClear),
        .IrqEnable    (IrqEnable),
        .CountEnable  (CountEnable),
        .CounterClear (CounterClear),
        .OverflowFlag (OverflowFlag),
        .CompareFlagA (CompareFlagA),
`ifdef TIMER_COMPARE_B_EN
        .CompareFlagB (CompareFlagB),
`endif
        .TimerIrq     (TimerIrq)
    );

`ifndef TIMER_COMPARE_B_EN
    assign CompareFlagB = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 stopped, 1 sync, 2 running; m_run counts running cycles
    // since the last restart; m_hist[k] is the pin value sampled k edges ago.
    int            m_phase   = 0;
    logic [2:0]    m_prev_cs = 3'd0;
    int            m_run     = 0;
    logic [NF-1:0] m_flags   = '0;
    logic [7:0]    m_cnt     = 8'd0;
    logic [3:0]    m_hist    = 4'd0;
    bit            auto_cnt  = 1'b0;
    logic          e_ce, e_cc, e_stable;
    logic [NF-1:0] e_set;
    logic          s_ce, s_cc;

    function automatic int divisor(input logic [2:0] cs);
        case (cs)
            3'd1: return 1;
            3'd2: return 8;
            3'd3: return 64;
            3'd4: return 256;
            3'd5: return 1024;
            default: return 0;
        endcase
    endfunction

    task automatic model_comb();
        logic tick;
        e_stable = (m_phase == 2) && (ClockSelect == m_prev_cs) && !ForceClear;
        tick = 1'b0;
        if (e_stable) begin
            if (divisor(ClockSelect) != 0) tick = ((m_run + 1) % divisor(ClockSelect)) == 0;
            else if (ClockSelect == 3'd7)  tick = m_hist[2] & ~m_hist[3];
            else if (ClockSelect == 3'd6)  tick = ~m_hist[2] & m_hist[3];
        end
        e_cc  = ForceClear || (tick && TimerMode && CounterValue == CompareA);
        e_ce  = tick && !(TimerMode && CounterValue == CompareA);
        e_set = '0;
        e_set[0] = tick && CounterValue == 8'hFF;
        e_set[1] = tick && CounterValue == CompareA;
`ifdef TIMER_COMPARE_B_EN
        e_set[2] = tick && CounterValue == CompareB;
`endif
    endtask

    task automatic model_seq();
        if (!SysResetN) begin
            m_phase = 0; m_prev_cs = 3'd0; m_run = 0; m_flags = '0; m_hist = 4'd0; m_cnt = 8'd0;
        end else begin
            m_flags = (m_flags & ~FlagClear) | e_set;
            if (e_cc) m_cnt = 8'd0;
            else if (e_ce) m_cnt = m_cnt + 8'd1;
            if (m_phase == 1 || ForceClear) m_run = 0;
            else if (e_stable) m_run++;
            if (ClockSelect == 3'd0) m_phase = 0;
            else if (m_phase == 0) m_phase = 1;
            else if (m_phase == 1) m_phase = 2;
            else if (ClockSelect != m_prev_cs) m_phase = 1;
            else m_phase = 2;
            m_prev_cs = ClockSelect;
            m_hist = {m_hist[2:0], ExtClockPin};
        end
    endtask

    // One clock: outputs checked at the falling edge, model advanced at the rising edge.
    task automatic cycle();
        if (auto_cnt) CounterValue = m_cnt;
        model_comb();
        @(negedge SysClock);
        s_ce = CountEnable;
        s_cc = CounterClear;
        check("model_ce", CountEnable, e_ce);
        check("model_cc", CounterClear, e_cc);
        check("model_tov", OverflowFlag, m_flags[0]);
        check("model_ocfa", CompareFlagA, m_flags[1]);
`ifdef TIMER_COMPARE_B_EN
        check("model_ocfb", CompareFlagB, m_flags[2]);
`endif
        check("model_irq", TimerIrq, |(m_flags & IrqEnable));
        @(posedge SysClock);
        model_seq();
        #1;
    endtask

    task automatic stop_and_clear();
        ClockSelect = 3'd0;
        FlagClear = '1;
        ForceClear = 1'b0;
        cycle();
        FlagClear = '0;
    endtask

    typedef struct packed {
        logic       mode;
        logic [7:0] cmpa;
        logic [7:0] cnt;
        logic [1:0] irqen;
        logic       exp_ce;
        logic       exp_cc;
        logic       exp_tov;
        logic       exp_ocfa;
        logic       exp_irq;
    } vec_t;

    vec_t vecs[10];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int pin_hold;
        vecs[0] = '{1'b0, 8'h10, 8'h03, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 8'h10, 8'h10, 2'b11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[2] = '{1'b0, 8'h10, 8'hFF, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 8'h05, 8'h05, 2'b10, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[4] = '{1'b1, 8'h05, 8'h04, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 8'h00, 8'h00, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{1'b1, 8'hFF, 8'hFF, 2'b11, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[7] = '{1'b0, 8'hFF, 8'hFF, 2'b10, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[8] = '{1'b1, 8'h05, 8'hFF, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[9] = '{1'b0, 8'h00, 8'h00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

        SysResetN = 1'b0; ClockSelect = 3'd1; TimerMode = 1'b0; CompareA = 8'h80;
        CompareB = 8'hAA; CounterValue = 8'h10; ExtClockPin = 1'b0; ForceClear = 1'b0;
        FlagClear = '0; IrqEnable = '0;
        @(posedge SysClock);
        #1;

        // Reset held with /1 selected, then release: STOPPED, SYNC, then ticks.
        cycle();
        check("rst_ce", s_ce, 1'b0);
        check("rst_cc", s_cc, 1'b0);
        check("rst_flags", {OverflowFlag, CompareFlagA, TimerIrq}, 3'b000);
        SysResetN = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("release_ce", s_ce, (i >= 2));
        end
        CounterValue = 8'hFF;
        cycle();
        check("release_tov", OverflowFlag, 1'b1);

        // Vector table: one tick at /1 per vector, from cleared flags.
        for (int v = 0; v < 10; v++) begin
            stop_and_clear();
            TimerMode = vecs[v].mode; CompareA = vecs[v].cmpa;
            CounterValue = vecs[v].cnt; IrqEnable = NF'(vecs[v].irqen);
            ClockSelect = 3'd1;
            cycle();
            cycle();
            cycle();
            check("vec_ce", s_ce, vecs[v].exp_ce);
            check("vec_cc", s_cc, vecs[v].exp_cc);
            check("vec_tov", OverflowFlag, vecs[v].exp_tov);
            check("vec_ocfa", CompareFlagA, vecs[v].exp_ocfa);
            check("vec_irq", TimerIrq, vecs[v].exp_irq);
        end

        // /8 period, then switch to /64 mid-run.
        stop_and_clear();
        TimerMode = 1'b0; CompareA = 8'h80; CounterValue = 8'h10; IrqEnable = '0;
        ClockSelect = 3'd2;
        n = 0;
        for (int i = 0; i < 34; i++) begin
            cycle();
            if (s_ce) begin
                check("div8_pos", i, 9 + 8 * n);
                n++;
            end
        end
        check("div8_count", n, 4);
        ClockSelect = 3'd3;
        n = 0;
        for (int i = 0; i < 70; i++) begin
            cycle();
            if (s_ce) begin
                check("div64_pos", i, 65);
                n++;
            end
        end
        check("div64_count", n, 1);

        // CTC at CompareA=5 with a counter that follows the pulses.
        stop_and_clear();
        auto_cnt = 1'b1;
        ForceClear = 1'b1;
        cycle();
        check("force_stopped_cc", s_cc, 1'b1);
        ForceClear = 1'b0;
        TimerMode = 1'b1; CompareA = 8'h05; ClockSelect = 3'd1;
        n = -1;
        for (int i = 0; i < 30; i++) begin
            cycle();
            if (s_cc) begin
                if (n >= 0) check("ctc_spacing", i - n, 6);
                n = i;
            end
        end
        check("ctc_tov", OverflowFlag, 1'b0);
        check("ctc_ocfa", CompareFlagA, 1'b1);
        CompareA = 8'h00;
        ForceClear = 1'b1;
        cycle();
        ForceClear = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            check("ctc0_cc", s_cc, 1'b1);
            check("ctc0_ce", s_ce, 1'b0);
        end
        auto_cnt = 1'b0;

        // External clock, rising then falling edge selection.
        stop_and_clear();
        TimerMode = 1'b0; CompareA = 8'h80; CounterValue = 8'h10;
        ClockSelect = 3'd7;
        for (int i = 0; i < 6; i++) cycle();
        n = 0;
        for (int i = 0; i < 16; i++) begin
            ExtClockPin = ((i % 8) < 4);
            cycle();
            if (s_ce) begin
                check("ext_rise_pos", i, 3 + 8 * n);
                n++;
            end
        end
        check("ext_rise_count", n, 2);
        ClockSelect = 3'd6;
        for (int i = 0; i < 8; i++) cycle();
        n = 0;
        for (int i = 0; i < 16; i++) begin
            ExtClockPin = ((i % 8) < 4);
            cycle();
            if (s_ce) begin
                check("ext_fall_pos", i, 7 + 8 * n);
                n++;
            end
        end
        check("ext_fall_count", n, 2);
        ExtClockPin = 1'b0;

        // Flag/IRQ interplay.
        stop_and_clear();
        ClockSelect = 3'd1; CompareA = 8'h80; CounterValue = 8'h10; IrqEnable = NF'(2'b01);
        cycle();
        cycle();
        CounterValue = 8'h80;
        cycle();
        CounterValue = 8'h10;
        check("irq_ocfa_set", CompareFlagA, 1'b1);
        check("irq_tov_only_off", TimerIrq, 1'b0);
        CounterValue = 8'hFF;
        cycle();
        check("irq_tov_only_on", TimerIrq, 1'b1);
        FlagClear = NF'(2'b01);
        cycle();
        check("set_beats_clear", OverflowFlag, 1'b1);
        ClockSelect = 3'd0;
        FlagClear = NF'(2'b11);
        cycle();
        FlagClear = '0;
        check("quiet_clear", {OverflowFlag, CompareFlagA, TimerIrq}, 3'b000);

        // ForceClear during a /64 run.
        stop_and_clear();
        ClockSelect = 3'd3; CounterValue = 8'hFF; CompareA = 8'hFF;
        for (int i = 0; i < 70; i++) cycle();
        check("div64_flags_set", {OverflowFlag, CompareFlagA}, 2'b11);
        CounterValue = 8'h10; CompareA = 8'h80;
        for (int i = 0; i < 10; i++) cycle();
        ForceClear = 1'b1;
        cycle();
        ForceClear = 1'b0;
        check("force_cc", s_cc, 1'b1);
        check("force_ce", s_ce, 1'b0);
        check("force_flags", {OverflowFlag, CompareFlagA}, 2'b11);
        n = 0;
        for (int i = 0; i < 70; i++) begin
            cycle();
            if (s_ce) begin
                check("force_next_tick", i, 63);
                n++;
            end
        end
        check("force_tick_count", n, 1);

        // Reset mid-run.
        stop_and_clear();
        ClockSelect = 3'd1; CounterValue = 8'h10;
        for (int i = 0; i < 4; i++) cycle();
        CounterValue = 8'hFF;
        cycle();
        CounterValue = 8'h10;
        SysResetN = 1'b0;
        cycle();
        check("midrst_ce", CountEnable, 1'b0);
        check("midrst_cc", CounterClear, 1'b0);
        check("midrst_tov", OverflowFlag, 1'b0);
        SysResetN = 1'b1;

        // Randomized traffic against the model.
        auto_cnt = 1'b1;
        pin_hold = 2;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) ClockSelect = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 59) == 0) TimerMode = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 29) == 0)
                CompareA = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 15));
            if ($urandom_range(0, 29) == 0) CompareB = 8'($urandom_range(0, 31));
            if ($urandom_range(0, 19) == 0) IrqEnable = NF'($urandom_range(0, 7));
            FlagClear  = ($urandom_range(0, 7) == 0) ? NF'($urandom_range(0, 7)) : '0;
            ForceClear = ($urandom_range(0, 49) == 0);
            SysResetN  = ($urandom_range(0, 499) != 0);
            pin_hold--;
            if (pin_hold <= 0) begin
                ExtClockPin = ~ExtClockPin;
                pin_hold = $urandom_range(2, 6);
            end
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
